// File: rtl/tick_timer_arbiter_if.sv
// Handshake bundle between timing consumers and the shared tick counter.
// The consumers drive req/req_period; the arbiter drives the rest.
interface tick_timer_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_period;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [WIDTH-1:0]         count;

    modport master (
        output req, req_period,
        input  gnt, done, busy, count
    );

    modport slave (
        input  req, req_period,
        output gnt, done, busy, count
    );
endinterface

// File: rtl/tick_timer_arbiter.sv
// Shared tick counter time-multiplexed between NUM_REQ requesters.
// TICK_TIMER_ARB_RR_EN selects round-robin, otherwise lowest index wins.
module tick_timer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    tick_timer_arbiter_if.slave   bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [IW-1:0]    win;
    logic             found;

`ifdef TICK_TIMER_ARB_RR_EN
    logic [IW-1:0] last_q;
    logic          retire;

    // Search upward from last+1 so the previous owner ranks lowest.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && bus.req[(int'(last_q) + i) % NUM_REQ]) begin
                win   = IW'((int'(last_q) + i) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    assign retire = (state_q == RUN) &&
                    (!bus.req[owner_q] || count_q == period_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= IW'(NUM_REQ - 1);
        end else if (retire) begin
            last_q <= owner_q;
        end
    end
`else
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req[i]) begin
                win   = IW'(i);
                found = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            period_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            period_q <= period_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        period_d = period_q;
        count_d  = count_q;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (found) begin
                    state_d  = RUN;
                    owner_d  = win;
                    period_d = bus.req_period[int'(win)*WIDTH +: WIDTH];
                end
            end
            RUN: begin
                // Abandonment wins over terminal count.
                if (!bus.req[owner_q]) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (count_q == period_q) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.gnt  = '0;
        bus.done = '0;
        bus.busy = 1'b0;
        unique case (state_q)
            RUN: begin
                bus.gnt[owner_q] = 1'b1;
                bus.busy         = 1'b1;
            end
            DONE: begin
                bus.done[owner_q] = 1'b1;
                bus.busy          = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    assign bus.count = count_q;
endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Directed bench for tick_timer_arbiter with a service-level reference model.
// Honours TICK_TIMER_ARB_RR_EN for the expected arbitration order.
module tb_tick_timer_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   armed = 1'b0;

    tick_timer_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    tick_timer_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d",
                     name, act, exp, cyc);
        end
    endtask

    // Service model: owner (-1 when idle) and age = cycles since grant.
    // age 0..P is the counting window, age P+1 is the completion cycle.
    int m_owner = -1;
    int m_age = 0;
    int m_period = 0;
    int m_last = N - 1;

    function automatic int pick(logic [N-1:0] r, int last);
`ifdef TICK_TIMER_ARB_RR_EN
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
`else
        for (int k = 0; k < N; k++)
            if (r[k]) return k;
`endif
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_owner = -1;
            m_age = 0;
            m_period = 0;
            m_last = N - 1;
        end else if (m_owner < 0) begin
            if (bus.req != '0) begin
                m_owner = pick(bus.req, m_last);
                m_period = int'(bus.req_period[m_owner*W +: W]);
                m_age = 0;
            end
        end else if (m_age <= m_period) begin
            if (!bus.req[m_owner]) begin
                m_last = m_owner;
                m_owner = -1;
                m_age = 0;
            end else begin
                if (m_age == m_period) m_last = m_owner;
                m_age++;
            end
        end else begin
            m_owner = -1;
            m_age = 0;
        end
    end

    logic [N-1:0] e_gnt, e_done, prev_gnt;
    logic [W-1:0] e_count;
    logic         e_busy;
    int gnt_cycles[N];
    int done_cnt[N];
    int order_q[$];
    int start_q[$];

    always @(negedge clk) begin
        if (armed) begin
            e_gnt = '0;
            e_done = '0;
            e_busy = (m_owner >= 0);
            e_count = '0;
            if (m_owner >= 0) begin
                if (m_age <= m_period) e_gnt[m_owner] = 1'b1;
                else e_done[m_owner] = 1'b1;
                e_count = W'((m_age < m_period) ? m_age : m_period);
            end
            chk("gnt", 32'(bus.gnt), 32'(e_gnt));
            chk("done", 32'(bus.done), 32'(e_done));
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("count", 32'(bus.count), 32'(e_count));
            for (int i = 0; i < N; i++) begin
                if (bus.gnt[i]) gnt_cycles[i]++;
                if (bus.done[i]) done_cnt[i]++;
                if (bus.gnt[i] && prev_gnt == '0) begin
                    order_q.push_back(i);
                    start_q.push_back(cyc);
                end
            end
            prev_gnt = bus.gnt;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin
            gnt_cycles[i] = 0;
            done_cnt[i] = 0;
        end
        order_q.delete();
        start_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req = '0;
        tick();
        armed = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        clear_stats();
    endtask

    task automatic set_period(int i, int p);
        bus.req_period[i*W +: W] = W'(p);
    endtask

    task automatic wait_done(int i, int maxc, string nm);
        int n = 0;
        while (!bus.done[i] && n < maxc) begin
            tick();
            n++;
        end
        chk(nm, 32'(bus.done[i]), 32'd1);
    endtask

    task automatic wait_count(int i, int v, int maxc, string nm);
        int n = 0;
        while (!(bus.gnt[i] && int'(bus.count) == v) && n < maxc) begin
            tick();
            n++;
        end
        chk(nm, 32'(bus.gnt[i] && int'(bus.count) == v), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ord[5];
        int c;
        bus.req = '0;
        bus.req_period = '0;
        prev_gnt = '0;
        clear_stats();

        // Reset state and a single period-5 service.
        do_reset();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        set_period(0, 5);
        bus.req = 4'b0001;
        wait_done(0, 40, "single_done_timeout");
        chk("single_done_count", 32'(bus.count), 32'd5);
        bus.req = '0;
        repeat (3) tick();
        chk("single_gnt_cycles", 32'(gnt_cycles[0]), 32'd6);
        chk("single_done_pulses", 32'(done_cnt[0]), 32'd1);

        // Period 0 gives a one-cycle RUN.
        set_period(2, 0);
        bus.req = 4'b0100;
        wait_done(2, 20, "p0_done_timeout");
        bus.req = '0;
        repeat (3) tick();
        chk("p0_gnt_cycles", 32'(gnt_cycles[2]), 32'd1);
        chk("p0_done_pulses", 32'(done_cnt[2]), 32'd1);

        // All four held, period 2 each.
        do_reset();
        for (int i = 0; i < N; i++) set_period(i, 2);
        bus.req = 4'b1111;
        c = 0;
        while (order_q.size() < 5 && c < 100) begin
            tick();
            c++;
        end
        bus.req = '0;
        repeat (4) tick();
        chk("rr_grants", 32'(order_q.size()), 32'd5);
`ifdef TICK_TIMER_ARB_RR_EN
        exp_ord = '{0, 1, 2, 3, 0};
`else
        exp_ord = '{0, 0, 0, 0, 0};
`endif
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr_order%0d", k),
                32'((k < order_q.size()) ? order_q[k] : -1),
                32'(exp_ord[k]));
        chk("rr_spacing",
            32'((start_q.size() > 1) ? start_q[1] - start_q[0] : -1),
            32'd5);

        // Abort with requester 3 pending.
        do_reset();
        set_period(1, 10);
        set_period(3, 1);
        bus.req = 4'b1010;
        wait_count(1, 4, 30, "abort_reach_timeout");
        bus.req = 4'b1000;
        tick();
        chk("abort_gnt", 32'(bus.gnt), 32'd0);
        chk("abort_count", 32'(bus.count), 32'd0);
        tick();
        chk("abort_regrant", 32'(bus.gnt), 32'b1000);
        wait_done(3, 20, "abort_next_timeout");
        bus.req = '0;
        repeat (3) tick();
        chk("abort_no_done", 32'(done_cnt[1]), 32'd0);
        chk("abort_next_done", 32'(done_cnt[3]), 32'd1);

        // Reset in the middle of a service.
        do_reset();
        set_period(0, 9);
        bus.req = 4'b0001;
        wait_count(0, 3, 30, "mrst_reach_timeout");
        rst = 1'b0;
        tick();
        chk("mrst_gnt", 32'(bus.gnt), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_count", 32'(bus.count), 32'd0);
        rst = 1'b1;
        bus.req = '0;
        repeat (12) tick();
        chk("mrst_no_done", 32'(done_cnt[0]), 32'd0);

        // Maximum period.
        do_reset();
        set_period(2, 255);
        bus.req = 4'b0100;
        wait_done(2, 300, "max_done_timeout");
        bus.req = '0;
        repeat (3) tick();
        chk("max_gnt_cycles", 32'(gnt_cycles[2]), 32'd256);
        chk("max_done_pulses", 32'(done_cnt[2]), 32'd1);

        armed = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
